// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake, register-file read port and execute-side
// handshake/payload of the decode stage, bundled into one interface.
// The "slave" modport is the decode stage's view; "master" is its environment.
interface decode_stage_if #(
    parameter int unsigned N = 32
);
    // Upstream (fetch) handshake and instruction
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [N-1:0] in_pc;

    // Register-file read port
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;

    // Downstream (execute) handshake and decoded payload
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_alu_type;
    logic [N-1:0] out_in1;
    logic [N-1:0] out_in2;
    logic [4:0]   out_rd;
    logic         out_we;
    logic [N-1:0] out_pc;
    logic         out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr,
        output out_valid, out_alu_type, out_in1, out_in2, out_rd, out_we, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr,
        input  out_valid, out_alu_type, out_in1, out_in2, out_rd, out_we, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode for OP, OP-IMM, LUI and AUIPC into ALU operation and operands,
// with a valid/ready pipeline register toward execute.
// Build option: define DECODE_SKID_EN for a two-entry skid buffer (output register plus one
// spare) whose in_ready is a flop, cutting the out_ready -> in_ready combinational path.
// Without it a single output register is used and in_ready = !out_valid || out_ready.
module decode_stage #(
    parameter int unsigned N = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);
    // Shared ALU operation encoding
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluXor = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluAnd = 3'd4;

    // All legal opcodes end in 2'b11, so a full 7-bit compare also rejects compressed encodings
    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    typedef struct packed {
        logic [2:0]   alu;
        logic [N-1:0] in1;
        logic [N-1:0] in2;
        logic [4:0]   rd;
        logic         we;
        logic [N-1:0] pc;
        logic         illegal;
    } payload_t;

    function automatic logic [N-1:0] sext32(input logic [31:0] v);
        logic [N-1:0] r;
        r       = {N{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];
    assign rd     = bus.in_instr[11:7];

    assign bus.rs1_addr = bus.in_instr[19:15];
    assign bus.rs2_addr = bus.in_instr[24:20];

    payload_t dec;
    logic     dec_legal;

    // Decode the incoming instruction and select operands; illegal words get zero operands.
    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        dec.alu   = AluAdd;
        dec.rd    = rd;
        dec.pc    = bus.in_pc;
        case (opcode)
            OpcOp: begin
                dec.in1 = bus.rs1_data;
                dec.in2 = bus.rs2_data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec.alu   = AluAdd;
                            dec_legal = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            dec.alu   = AluSub;
                            dec_legal = 1'b1;
                        end
                    end
                    3'b100: begin
                        dec.alu   = AluXor;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b110: begin
                        dec.alu   = AluOr;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b111: begin
                        dec.alu   = AluAnd;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    default: ;
                endcase
            end
            OpcOpImm: begin
                dec.in1 = bus.rs1_data;
                dec.in2 = sext32({{20{bus.in_instr[31]}}, bus.in_instr[31:20]});
                case (funct3)
                    3'b000: begin
                        dec.alu   = AluAdd;
                        dec_legal = 1'b1;
                    end
                    3'b100: begin
                        dec.alu   = AluXor;
                        dec_legal = 1'b1;
                    end
                    3'b110: begin
                        dec.alu   = AluOr;
                        dec_legal = 1'b1;
                    end
                    3'b111: begin
                        dec.alu   = AluAnd;
                        dec_legal = 1'b1;
                    end
                    default: ;
                endcase
            end
            OpcLui: begin
                dec_legal = 1'b1;
                dec.in2   = sext32({bus.in_instr[31:12], 12'b0});
            end
            OpcAuipc: begin
                dec_legal = 1'b1;
                dec.in1   = bus.in_pc;
                dec.in2   = sext32({bus.in_instr[31:12], 12'b0});
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec.alu = AluAdd;
            dec.in1 = '0;
            dec.in2 = '0;
        end
        dec.we      = dec_legal && (rd != 5'd0);
        dec.illegal = !dec_legal;
    end

    payload_t out_q, out_d;
    logic     out_valid_q, out_valid_d;
    logic     in_fire, out_fire;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

`ifdef DECODE_SKID_EN
    payload_t spare_q, spare_d;
    logic     spare_valid_q, spare_valid_d;

    assign bus.in_ready = !spare_valid_q;

    // Output slot refills from the spare first so ordering is kept; spare only fills on a stall.
    always_comb begin
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        spare_d       = spare_q;
        spare_valid_d = spare_valid_q;
        if (flush) begin
            out_valid_d   = 1'b0;
            spare_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            if (spare_valid_q) begin
                out_d         = spare_q;
                out_valid_d   = 1'b1;
                spare_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            spare_d       = dec;
            spare_valid_d = 1'b1;
        end
    end

    // Skid buffer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            spare_q       <= '0;
            spare_valid_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            spare_q       <= spare_d;
            spare_valid_q <= spare_valid_d;
        end
    end
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    // Single output register: load on accept, empty on drain, flush wins over both.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign bus.out_valid    = out_valid_q;
    assign bus.out_alu_type = out_q.alu;
    assign bus.out_in1      = out_q.in1;
    assign bus.out_in2      = out_q.in2;
    assign bus.out_rd       = out_q.rd;
    assign bus.out_we       = out_q.we;
    assign bus.out_pc       = out_q.pc;
    assign bus.out_illegal  = out_q.illegal;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: N, default 32, datapath width of the operand outputs and in_pc (N >= 32).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1, in_ready  output  1  upstream (fetch) handshake; transfer when both high at a clk edge.
REQ-005 Port: in_instr  input  32  RV32I instruction word; in_pc  input  N  its address.
REQ-006 Port: rs1_addr, rs2_addr  output  5 each  register-file read addresses, combinational from in_instr[19:15], in_instr[24:20].
REQ-007 Port: rs1_data, rs2_data  input  N each  register-file read data, valid in the same cycle as the address.
REQ-008 Port: flush  input  1  discard all held and incoming instructions.
REQ-009 Port: out_valid  output  1, out_ready  input  1  downstream (execute) handshake.
REQ-010 Port: out_alu_type  output  3  ALU operation code per the shared ALU encoding (ADD, SUB, XOR, OR, AND).
REQ-011 Port: out_in1, out_in2  output  N each  ALU operands; out_rd  output  5; out_we  output  1  register write enable; out_pc  output  N; out_illegal  output  1.

Function
REQ-012 Decode opcode 0110011 (OP): funct3 000 with funct7 0000000 -> ADD, funct7 0100000 -> SUB; 100 -> XOR; 110 -> OR; 111 -> AND; in1=rs1_data, in2=rs2_data; any other funct3/funct7 -> illegal.
REQ-013 Decode opcode 0010011 (OP-IMM): funct3 000/100/110/111 -> ADD/XOR/OR/AND; in1=rs1_data, in2=sign-extended in_instr[31:20] to N bits; other funct3 -> illegal.
REQ-014 Decode LUI (0110111): ADD, in1=0, in2={in_instr[31:12],12'b0} sign-extended to N; AUIPC (0010111): same but in1=in_pc.
REQ-015 Any other opcode, or in_instr[1:0] != 2'b11: out_illegal=1, out_we=0, out_alu_type=ADD, out_in1=out_in2=0.
REQ-016 out_we = legal AND rd != 0; out_rd = in_instr[11:7] always.
REQ-017 Latency: an instruction accepted at edge k is presented with out_valid=1 after edge k; one instruction per cycle sustained when out_ready stays high.
REQ-018 Output payload stable while out_valid=1 and out_ready=0; no instruction dropped, duplicated or reordered.
REQ-019 flush=1 at an edge: out_valid and all held entries cleared; an input handshaking in that same cycle is discarded; flush overrides out_ready and in_valid.
REQ-020 Simultaneous drain and accept (out_valid&out_ready and in_valid&in_ready) in one cycle: new instruction replaces the drained one with no bubble.

Reset
REQ-021 rst_n low asynchronously forces out_valid=0, all payload outputs (alu_type, in1, in2, rd, we, pc, illegal) to 0, skid entry empty.
REQ-022 in_ready=1 during and after reset; first accept possible at the first edge after rst_n deasserts.
REQ-023 Reset asserted mid-transfer discards all held instructions; no partial state survives.

Configuration
REQ-024 Macro DECODE_SKID_EN defined: two-entry skid buffer (output register plus one spare); in_ready is a register output = spare entry empty; no combinational path from out_ready to in_ready.
REQ-025 DECODE_SKID_EN undefined: single output register; in_ready = !out_valid || out_ready (combinational); REQ-017 to REQ-020 still hold.

Verification
REQ-026 Reset then in_instr=0x00308133 (add x2,x1,x3), rs1=5, rs2=7, out_ready=1 -> next cycle out_alu_type=ADD, in1=5, in2=7, rd=2, we=1.
REQ-027 in_instr=0x40308133 (sub), then 0xFFF0C093 (xori x1,x1,-1) back-to-back -> SUB then XOR with in2=0xFFFFFFFF, one per cycle, no bubble.
REQ-028 in_instr=0x12345037 (lui x0) -> in1=0, in2=0x12345000, we=0; in_instr=0xFFFFFFFF -> illegal=1, we=0, in1=in2=0.
REQ-029 out_ready=0 for 5 cycles with in_valid=1 streaming -> payload held constant, at most 2 (skid) / 1 (no skid) accepted, then all drained in order.
REQ-030 flush=1 with out_valid=1, spare entry full and in_valid=1 -> next cycle out_valid=0, nothing from those three instructions ever emitted.
REQ-031 rst_n pulsed low mid-stream between edges -> out_valid=0 immediately, in_ready=1, subsequent stream decodes correctly.
